pl_fetch_stage: RTL

Instruction-fetch stage of the MIPS pipeline. It holds the PC register and the IF/ID pipeline register, and drives the instruction-memory address. It consumes the load-use stall controls (pc_write, IF_ID_write) from the hazard detection unit and the branch/jump redirect from the EX stage. It feeds the ID stage with the instruction, PC+4 and a valid bit, and keeps fetch and stall performance counters.

---
 rtl/pl_fetch_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pl_fetch_stage.sv
// -----------------------------------------------------------------------------
// pl_fetch_stage
//
// This is the instruction-fetch stage of a classic five-stage MIPS pipeline.
// It holds the program counter and the IF/ID pipeline register, and it drives
// the instruction-memory address straight from the PC register.
//
// Update priority on each RUN edge, highest first:
//   1. A redirect (taken branch or jump) always wins. It loads the word-aligned
//      target into the PC and flushes IF/ID.
//   2. A load-use hold (IF_ID_write=0) freezes IF/ID.
//   3. A memory wait (imem_ready=0) holds the PC and inserts a bubble.
//   4. Otherwise the fetched word is loaded into IF/ID.
// BOOT lasts for the single edge after reset release and does nothing.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   pc_write        : 1 = PC may advance
//   IF_ID_write     : 1 = IF/ID may load
//   redirect_valid  : flush and redirect to redirect_pc
//   redirect_pc     : redirect target (bits [1:0] dropped, flagged if nonzero)
//   imem_addr       : instruction address (the PC register)
//   imem_rdata      : instruction word at imem_addr (combinational read)
//   imem_ready      : imem_rdata valid this cycle
//   if_id_instr     : registered instruction for ID
//   if_id_pc_plus4  : registered PC+4 of if_id_instr
//   if_id_valid     : 1 = if_id_instr is a real fetched instruction
//   misaligned      : sticky flag for a redirect target with nonzero [1:0]
//   fetch_count     : valid IF/ID loads (wraps)
//   stall_count     : RUN edges with no redirect and no PC advance (wraps)
// -----------------------------------------------------------------------------
module pl_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        IF_ID_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misaligned,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential PC increment. The addition wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] if_id_instr_r;
  logic [31:0] if_id_pc_plus4_r;
  logic        if_id_valid_r;
  logic        misaligned_r;
  logic [31:0] fetch_count_r;
  logic [31:0] stall_count_r;

  logic [31:0] pc_plus4_s;
  logic [31:0] pc_next_s;
  logic [31:0] instr_next_s;
  logic [31:0] pc4_next_s;
  logic        valid_next_s;
  logic        misaligned_next_s;
  logic        fetch_inc_s;
  logic        stall_inc_s;

  assign pc_plus4_s = next_seq_pc(pc_r);

  // Next-value selection for the PC, IF/ID and counters, in priority order.
  always_comb begin
    pc_next_s         = pc_r;
    instr_next_s      = if_id_instr_r;
    pc4_next_s        = if_id_pc_plus4_r;
    valid_next_s      = if_id_valid_r;
    misaligned_next_s = misaligned_r;
    fetch_inc_s       = 1'b0;
    stall_inc_s       = 1'b0;

    if (state_r == ST_RUN) begin
      if (redirect_valid) begin
        // The redirecting instruction is older than any stalled one, so it
        // overrides every hold and every memory wait.
        pc_next_s         = word_align(redirect_pc);
        instr_next_s      = NOP_INSTR;
        pc4_next_s        = 32'h0000_0000;
        valid_next_s      = 1'b0;
        misaligned_next_s = misaligned_r | (redirect_pc[1:0] != 2'b00);
      end else if (!IF_ID_write) begin
        // IF/ID is frozen. The hazard unit normally lowers pc_write at the
        // same time, so the PC holds too.
        if (pc_write && imem_ready) begin
          pc_next_s = pc_plus4_s;
        end else begin
          pc_next_s = pc_r;
        end
      end else if (!imem_ready) begin
        pc_next_s    = pc_r;
        instr_next_s = NOP_INSTR;
        pc4_next_s   = 32'h0000_0000;
        valid_next_s = 1'b0;
      end else begin
        instr_next_s = imem_rdata;
        pc4_next_s   = pc_plus4_s;
        valid_next_s = 1'b1;
        fetch_inc_s  = 1'b1;
        if (pc_write) begin
          pc_next_s = pc_plus4_s;
        end else begin
          pc_next_s = pc_r;
        end
      end

      // Without a redirect, the PC moves only when pc_write and imem_ready
      // are both high.
      stall_inc_s = !redirect_valid && !(pc_write && imem_ready);
    end else begin
      // BOOT: leave all state unchanged.
      pc_next_s = pc_r;
    end
  end

  // State register, PC, IF/ID, sticky flag and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_BOOT;
      pc_r             <= RESET_PC;
      if_id_instr_r    <= NOP_INSTR;
      if_id_pc_plus4_r <= 32'h0000_0000;
      if_id_valid_r    <= 1'b0;
      misaligned_r     <= 1'b0;
      fetch_count_r    <= 32'h0000_0000;
      stall_count_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_BOOT: state_r <= ST_RUN;
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_BOOT;
      endcase
      pc_r             <= pc_next_s;
      if_id_instr_r    <= instr_next_s;
      if_id_pc_plus4_r <= pc4_next_s;
      if_id_valid_r    <= valid_next_s;
      misaligned_r     <= misaligned_next_s;
      if (fetch_inc_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
      if (stall_inc_s) begin
        stall_count_r <= stall_count_r + 32'd1;
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign imem_addr      = pc_r;
  assign if_id_instr    = if_id_instr_r;
  assign if_id_pc_plus4 = if_id_pc_plus4_r;
  assign if_id_valid    = if_id_valid_r;
  assign misaligned     = misaligned_r;
  assign fetch_count    = fetch_count_r;
  assign stall_count    = stall_count_r;

endmodule
